// File: rtl/data_memory_unit.sv
// Byte-addressable big-endian data memory with zero-fill on reset, one-cycle load latency,
// fault detection (misalign / overflow) and sticky error flags.
module data_memory_unit #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              rsp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              rsp_err_o,
    input  logic              err_clr_i,
    output logic [1:0]        err_sticky_o
);

    localparam int                WORDS     = DEPTH_BYTES / 4;
    localparam int                WIDX_W    = $clog2(WORDS);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);

    typedef enum logic {ST_INIT, ST_IDLE} state_e;

    state_e            state_q;
    logic [WIDX_W-1:0] cnt_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rdata_q;
    logic [1:0]        sticky_q;
    logic [1:0]        sticky_d;
    logic [31:0]       mem_q [WORDS];

    logic [2:0]        acc_bytes;
    logic [ADDR_W:0]   end_addr;
    logic              ovf;
    logic              mis;
    logic              fault;
    logic              accept;
    logic              wr_en;
    logic [WIDX_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic [15:0]       half_sel;
    logic [7:0]        byte_sel;
    logic [31:0]       ld_data;

    always_comb begin
        acc_bytes = 3'd0;
        mis       = 1'b0;
        case (size_i)
            2'b11: begin acc_bytes = 3'd4; mis = (addr_i[1:0] != 2'b00); end
            2'b10: begin acc_bytes = 3'd2; mis = addr_i[0]; end
            2'b01: begin acc_bytes = 3'd1; mis = 1'b0; end
            default: begin acc_bytes = 3'd0; mis = 1'b1; end
        endcase
    end

    // Extra top bit keeps the end address from wrapping near the top of the address space.
    assign end_addr = {1'b0, addr_i} + {{(ADDR_W-2){1'b0}}, acc_bytes};
    assign ovf      = (end_addr > DEPTH_EXT);
    assign fault    = mis | ovf;
    assign accept   = req_i & ready_q;
    assign wr_en    = accept & we_i & ~fault;
    assign word_idx = addr_i[WIDX_W+1:2];
    assign rd_word  = mem_q[word_idx];

    always_comb begin
        half_sel = addr_i[1] ? rd_word[15:0] : rd_word[31:16];
        byte_sel = 8'h00;
        case (addr_i[1:0])
            2'b00: byte_sel = rd_word[31:24];
            2'b01: byte_sel = rd_word[23:16];
            2'b10: byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
    end

    always_comb begin
        ld_data = '0;
        case (size_i)
            2'b11: ld_data = rd_word;
            2'b10: ld_data = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            2'b01: ld_data = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            default: ld_data = '0;
        endcase
    end

    // Lowest address maps to the most-significant lane of the stored word.
    always_comb begin
        wr_word = rd_word;
        case (size_i)
            2'b11: wr_word = wdata_i;
            2'b10: begin
                if (addr_i[1]) wr_word[15:0]  = wdata_i[15:0];
                else           wr_word[31:16] = wdata_i[15:0];
            end
            2'b01: begin
                case (addr_i[1:0])
                    2'b00: wr_word[31:24] = wdata_i[7:0];
                    2'b01: wr_word[23:16] = wdata_i[7:0];
                    2'b10: wr_word[15:8]  = wdata_i[7:0];
                    default: wr_word[7:0] = wdata_i[7:0];
                endcase
            end
            default: wr_word = rd_word;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // A clear and a new fault in the same cycle leaves the bit set.
    assign sticky_d = (sticky_q & ~{2{err_clr_i}}) | ({ovf, mis} & {2{accept}});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            sticky_q    <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: ready_q <= 1'b1;
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & fault;
            rdata_q     <= (accept & ~we_i & ~fault) ? ld_data : '0;
            sticky_q    <= sticky_d;
        end
    end

    assign ready_o      = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rdata_o      = rdata_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: a byte-array reference model predicts each response,
// and a monitor pops and compares every response pulse against it.
module tb_data_memory_unit;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  size = 2'b11;
    logic        uns = 1'b0;
    logic [31:0] wdata = '0;
    logic        err_clr = 1'b0;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        rsp_err;
    logic [1:0]  sticky;

    data_memory_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .size_i(size), .unsigned_i(uns), .wdata_i(wdata), .ready_o(ready),
        .rsp_valid_o(rsp_valid), .rdata_o(rdata), .rsp_err_o(rsp_err),
        .err_clr_i(err_clr), .err_sticky_o(sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  model [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rdata", rdata, mon_e.data);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
                    check("rsp_latency", cyc, mon_e.cyc + 1);
                end
            end else begin
                check("idle_out_zero", (rdata != 0 || rsp_err) ? 32'd1 : 32'd0, 32'd0);
                if (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
                    check("missing_rsp", 32'd1, 32'd0);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    // Drives one request at the next negedge (left asserted for back-to-back use) and predicts its response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd, input logic clr);
        int          n;
        int          nb;
        logic        m;
        logic        o;
        logic [32:0] endp;
        logic [31:0] acc;
        exp_t        e;
        @(negedge clk);
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
        req = 1'b1; we = w; addr = a; size = sz; uns = u; wdata = wd; err_clr = clr;
        case (sz)
            2'b11: begin nb = 4; m = (a[1:0] != 2'b00); end
            2'b10: begin nb = 2; m = a[0]; end
            2'b01: begin nb = 1; m = 1'b0; end
            default: begin nb = 0; m = 1'b1; end
        endcase
        endp = {1'b0, a} + 33'(nb);
        o = (endp > 33'(DEPTH));
        e.cyc = cyc;
        e.err = m | o;
        e.data = '0;
        if (!(m | o)) begin
            if (w) begin
                for (int i = 0; i < nb; i++) model[int'(a) + i] = wd[8*(nb-1-i) +: 8];
            end else begin
                acc = '0;
                for (int i = 0; i < nb; i++) acc = {acc[23:0], model[int'(a) + i]};
                if (nb == 2 && !u && acc[15]) acc = acc | 32'hFFFF_0000;
                if (nb == 1 && !u && acc[7])  acc = acc | 32'hFFFF_FF00;
                e.data = acc;
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0; we = 1'b0; err_clr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic count_init(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 1000);
    endtask

    task automatic clear_sticky();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          nb;
        logic [1:0]  sz;
        logic [31:0] a;
        exp_t        e;

        model_clear();
        #2 rst = 1'b1;
        #1;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_sticky", {30'b0, sticky}, 32'd0);
        repeat (3) @(negedge clk);

        // Held word load at 0x10 must wait out the full zero-fill.
        req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'b11; uns = 1'b0;
        mon_en = 1'b1;
        rst = 1'b0;
        count_init(n);
        check("init_cycles", n, 32'd256);
        e.cyc = cyc; e.err = 1'b0; e.data = 32'h0;
        sb.push_back(e);
        @(posedge clk);

        issue(1'b1, 32'h20, 2'b11, 1'b0, 32'h8091_A2B3, 1'b0);
        issue(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h21, 2'b01, 1'b1, 32'h0, 1'b0);
        issue(1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 2'b10, 1'b1, 32'h0, 1'b0);
        idle(2);
        check("exp_0x21_signed", 32'hFFFF_FF91, {24'hFFFFFF, model[33]});
        check("sticky_clean", {30'b0, sticky}, 32'd0);

        issue(1'b0, 32'h02, 2'b11, 1'b0, 32'h0, 1'b0);
        idle(2);
        check("sticky_misalign", {30'b0, sticky}, 32'd1);

        issue(1'b1, 32'h3FC, 2'b11, 1'b0, 32'h1122_3344, 1'b0);
        issue(1'b1, 32'h3FE, 2'b11, 1'b0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 32'h3FC, 2'b11, 1'b0, 32'h0, 1'b0);
        idle(2);
        check("sticky_both", {30'b0, sticky}, 32'd3);

        issue(1'b0, 32'h400, 2'b01, 1'b1, 32'h0, 1'b1);
        idle(2);
        check("sticky_set_and_clr", {30'b0, sticky}, 32'd2);
        clear_sticky();
        @(negedge clk);
        check("sticky_cleared", {30'b0, sticky}, 32'd0);

        issue(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 32'h3FF, 2'b01, 1'b0, 32'h0000_00A5, 1'b0);
        issue(1'b0, 32'h3FF, 2'b01, 1'b0, 32'h0, 1'b0);
        idle(2);
        check("sticky_size0", {30'b0, sticky}, 32'd1);
        clear_sticky();

        issue(1'b1, 32'h40, 2'b11, 1'b0, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 32'h40, 2'b11, 1'b1, 32'h0, 1'b0);
        issue(1'b1, 32'h41, 2'b01, 1'b0, 32'h0000_0077, 1'b0);
        issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1'b0);
        issue(1'b1, 32'h42, 2'b10, 1'b0, 32'h0000_8001, 1'b0);
        issue(1'b0, 32'h40, 2'b11, 1'b0, 32'h0, 1'b0);
        idle(2);

        for (int k = 0; k < 80; k++) begin
            sz = 2'($urandom_range(1, 3));
            nb = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
            a = 32'($urandom_range(0, DEPTH / nb - 1) * nb);
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(0, DEPTH + 8));
            issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);
        clear_sticky();

        // Reset with a fault latched and a load response due in the next cycle.
        issue(1'b0, 32'h02, 2'b11, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd0);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_err", {31'b0, rsp_err}, 32'd0);
        check("mid_rst_sticky", {30'b0, sticky}, 32'd0);
        req = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_init(n);
        check("reinit_cycles", n, 32'd256);
        issue(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h40, 2'b11, 1'b0, 32'h0, 1'b0);
        issue(1'b0, 32'h3FC, 2'b11, 1'b0, 32'h0, 1'b0);
        idle(3);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
